// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and frame constants for the UART transmit path.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

endpackage
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : baud_tick_gen
// Brief   : Bit-period tick generator; counter preloads while disabled.
// Revision: 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int c_div = (CLK_FREQ / (BAUD * OVERSAMPLE) > 0) ? CLK_FREQ / (BAUD * OVERSAMPLE) : 1;
    localparam int c_cw  = (c_div > 1) ? $clog2(c_div) : 1;

    logic [c_cw-1:0] r_cnt;
    logic            r_tick;

    // Registered tick: the first tick lands exactly c_div cycles after the enable cycle.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == c_cw'(c_div - 1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_sched
// Brief   : Round-robin scheduler sharing one 8N1 transmitter between NREQ sources.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 115200,
    parameter int NREQ     = 2,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx,
    output logic              busy,
    output logic [IDW-1:0]    grant_id
);

    tx_state_t      r_state;
    tx_state_t      w_next_state;
    logic [7:0]     r_shift;
    logic [2:0]     r_bitcnt;
    logic           r_tx;
    logic           w_tx_d;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] r_last_grant;
    logic [IDW-1:0] w_pick;
    logic [7:0]     w_byte;
    logic           w_accept;
    logic           w_tick;
    logic           w_busy_next;

    // First valid requester searching upward from last+1, with wrap.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  last);
        logic [IDW-1:0] pick;
        int             idx;
        pick = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (valid[idx]) pick = IDW'(idx);
        end
        return pick;
    endfunction

    assign w_pick      = rr_pick(req_valid, r_last_grant);
    assign w_busy_next = (w_next_state != IDLE);

    baud_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (1)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (w_busy_next),
        .tick   (w_tick)
    );

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        req_ready    = '0;
        w_byte       = 8'h00;
        w_tx_d       = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == IDW'(i)) w_byte = req_data[8*i +: 8];
        end
        case (r_state)
            IDLE: begin
                if (|req_valid && !rst) begin
                    w_accept     = 1'b1;
                    w_next_state = START;
                end
            end
            START: begin
                w_tx_d = 1'b0;
                if (w_tick) w_next_state = DATA;
            end
            DATA: begin
                w_tx_d = r_shift[0];
                if (w_tick && r_bitcnt == 3'(DATA_BITS - 1)) w_next_state = STOP;
            end
            STOP: begin
                if (w_tick) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        if (w_accept) req_ready[w_pick] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_tx         <= 1'b1;
            r_shift      <= 8'h00;
            r_bitcnt     <= 3'd0;
            r_grant_id   <= '0;
            r_last_grant <= IDW'(NREQ - 1);
        end else begin
            r_state <= w_next_state;
            r_tx    <= w_tx_d;
            if (w_accept) begin
                r_shift      <= w_byte;
                r_bitcnt     <= 3'd0;
                r_grant_id   <= w_pick;
                r_last_grant <= w_pick;
            end else if (r_state == DATA && w_tick) begin
                r_shift  <= {1'b0, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end else if (r_state == START && w_tick) begin
                r_bitcnt <= 3'd0;
            end
        end
    end

    assign tx       = r_tx;
    assign busy     = (r_state != IDLE);
    assign grant_id = r_grant_id;

endmodule
`default_nettype wire
